// File: rtl/idle_wake_ctrl.sv
// rtl/idle_wake_ctrl.sv - idle/wake power-state sequencer driving clock_gate set/clear
// Runs on the ungated aclk: drains the memory side, gates the core clock, and restarts it on wake.
module idle_wake_ctrl #(
    parameter int NUM_INT       = 13,
    parameter int DRAIN_STABLE  = 4,
    parameter int DRAIN_TIMEOUT = 1024,
    parameter int MIN_SLEEP     = 2,
    parameter int CNT_W         = 32
) (
    input  logic               aclk,
    input  logic               reset,
    input  logic               idle_req,
    input  logic               bus_idle,
    input  logic [NUM_INT-1:0] int_pending,
    input  logic [NUM_INT-1:0] int_enable,
    input  logic               force_wake,
    output logic               clear_clock_gate,
    output logic               set_clock_gate,
    output logic               core_sleeping,
    output logic               idle_abort,
    output logic               wake_done,
    output logic [CNT_W-1:0]   sleep_cycles
);

    localparam int DC_W = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
    localparam int SC_W = $clog2(DRAIN_STABLE + 1);
    localparam int SL_W = $clog2(MIN_SLEEP + 1);

    typedef enum logic [2:0] {
        ST_RUN   = 3'd0,
        ST_DRAIN = 3'd1,
        ST_GATE  = 3'd2,
        ST_SLEEP = 3'd3,
        ST_WAKE  = 3'd4
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [DC_W-1:0]   drain_cnt;
    logic [DC_W-1:0]   drain_cnt_nxt;
    logic [SC_W-1:0]   stable_cnt;
    logic [SC_W-1:0]   stable_cnt_nxt;
    logic [SL_W-1:0]   sleep_cnt;
    logic [SL_W-1:0]   sleep_cnt_nxt;
    logic [SL_W-1:0]   sleep_cnt_inc;

    logic              wake;
    logic              drain_timeout;
    logic              drain_stable;
    logic              sleep_min_met;

    logic              clear_nxt;
    logic              set_nxt;
    logic              sleeping_nxt;
    logic              abort_nxt;
    logic              done_nxt;
    logic [CNT_W-1:0]  sleep_cycles_nxt;

    assign wake          = (|(int_pending & int_enable)) | force_wake;
    assign drain_timeout = (drain_cnt == DC_W'(DRAIN_TIMEOUT - 1));
    assign drain_stable  = bus_idle && (stable_cnt == SC_W'(DRAIN_STABLE - 1));
    // sleep_cnt_inc counts the current SLEEP cycle too, so MIN_SLEEP cycles of SLEEP are guaranteed
    assign sleep_cnt_inc = (sleep_cnt == SL_W'(MIN_SLEEP)) ? sleep_cnt : sleep_cnt + SL_W'(1);
    assign sleep_min_met = (sleep_cnt_inc == SL_W'(MIN_SLEEP));

    always_ff @(posedge aclk) begin
        if (reset) begin
            state            <= ST_RUN;
            drain_cnt        <= '0;
            stable_cnt       <= '0;
            sleep_cnt        <= '0;
            clear_clock_gate <= 1'b0;
            set_clock_gate   <= 1'b0;
            core_sleeping    <= 1'b0;
            idle_abort       <= 1'b0;
            wake_done        <= 1'b0;
            sleep_cycles     <= '0;
        end else begin
            state            <= state_nxt;
            drain_cnt        <= drain_cnt_nxt;
            stable_cnt       <= stable_cnt_nxt;
            sleep_cnt        <= sleep_cnt_nxt;
            clear_clock_gate <= clear_nxt;
            set_clock_gate   <= set_nxt;
            core_sleeping    <= sleeping_nxt;
            idle_abort       <= abort_nxt;
            wake_done        <= done_nxt;
            sleep_cycles     <= sleep_cycles_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        drain_cnt_nxt  = drain_cnt;
        stable_cnt_nxt = stable_cnt;
        sleep_cnt_nxt  = sleep_cnt;
        case (state)
            ST_RUN: begin
                drain_cnt_nxt  = '0;
                stable_cnt_nxt = '0;
                if (idle_req) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                drain_cnt_nxt  = drain_cnt + DC_W'(1);
                stable_cnt_nxt = bus_idle ? stable_cnt + SC_W'(1) : '0;
                // a wake during drain abandons the idle rather than gating and waking at once
                if (wake || drain_timeout) begin
                    state_nxt = ST_RUN;
                end else if (drain_stable) begin
                    state_nxt = ST_GATE;
                end
            end
            ST_GATE: begin
                sleep_cnt_nxt = '0;
                state_nxt     = ST_SLEEP;
            end
            ST_SLEEP: begin
                sleep_cnt_nxt = sleep_cnt_inc;
                if (wake && sleep_min_met) begin
                    state_nxt = ST_WAKE;
                end
            end
            ST_WAKE: begin
                state_nxt = ST_RUN;
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
    end

    always_comb begin
        clear_nxt        = (state == ST_GATE) || (state == ST_SLEEP);
        sleeping_nxt     = (state == ST_GATE) || (state == ST_SLEEP);
        set_nxt          = (state == ST_WAKE);
        done_nxt         = (state == ST_WAKE);
        abort_nxt        = (state == ST_DRAIN) && (wake || drain_timeout);
        sleep_cycles_nxt = sleep_cycles;
        if ((state == ST_SLEEP) && !(&sleep_cycles)) begin
            sleep_cycles_nxt = sleep_cycles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_idle_wake_ctrl.sv
// tb/tb_idle_wake_ctrl.sv - self-checking bench for idle_wake_ctrl
// Directed scenarios with literal expectations plus randomized traffic checked every cycle against a reference model.
module tb_idle_wake_ctrl;

    localparam int NUM_INT       = 13;
    localparam int DRAIN_STABLE  = 4;
    localparam int DRAIN_TIMEOUT = 1024;
    localparam int MIN_SLEEP     = 2;
    localparam int CNT_W         = 32;

    logic               aclk = 1'b0;
    logic               reset = 1'b1;
    logic               idle_req = 1'b0;
    logic               bus_idle = 1'b0;
    logic [NUM_INT-1:0] int_pending = '0;
    logic [NUM_INT-1:0] int_enable = '0;
    logic               force_wake = 1'b0;
    logic               clear_clock_gate;
    logic               set_clock_gate;
    logic               core_sleeping;
    logic               idle_abort;
    logic               wake_done;
    logic [CNT_W-1:0]   sleep_cycles;

    int n_tests = 0;
    int n_fail  = 0;

    idle_wake_ctrl #(
        .NUM_INT(NUM_INT), .DRAIN_STABLE(DRAIN_STABLE), .DRAIN_TIMEOUT(DRAIN_TIMEOUT),
        .MIN_SLEEP(MIN_SLEEP), .CNT_W(CNT_W)
    ) dut (
        .aclk(aclk), .reset(reset), .idle_req(idle_req), .bus_idle(bus_idle),
        .int_pending(int_pending), .int_enable(int_enable), .force_wake(force_wake),
        .clear_clock_gate(clear_clock_gate), .set_clock_gate(set_clock_gate),
        .core_sleeping(core_sleeping), .idle_abort(idle_abort), .wake_done(wake_done),
        .sleep_cycles(sleep_cycles)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks the idle episode as a drain age, a run of idle cycles and a sleep length.
    bit               m_started = 0;
    bit               m_draining, m_gating, m_waking;
    int               m_drain_age, m_streak, m_sleep_len;
    bit               m_wake;
    logic [CNT_W-1:0] m_total;
    bit               e_clear, e_set, e_sleeping, e_abort, e_done;

    always @(posedge aclk) begin
        m_started = 1;
        if (reset) begin
            m_draining = 0; m_gating = 0; m_waking = 0;
            m_drain_age = 0; m_streak = 0; m_sleep_len = -1;
            m_total = '0;
            e_clear = 0; e_set = 0; e_sleeping = 0; e_abort = 0; e_done = 0;
        end else begin
            m_wake     = ((int_pending & int_enable) != '0) || force_wake;
            e_abort    = 0;
            e_set      = 0;
            e_done     = 0;
            e_sleeping = m_gating || (m_sleep_len >= 0);
            if (m_waking) begin
                e_clear  = 0;
                e_set    = 1;
                e_done   = 1;
                m_waking = 0;
            end else if (m_sleep_len >= 0) begin
                e_clear = 1;
                if (m_total != {CNT_W{1'b1}}) m_total = m_total + 1;
                m_sleep_len++;
                if (m_wake && m_sleep_len >= MIN_SLEEP) begin
                    m_sleep_len = -1;
                    m_waking    = 1;
                end
            end else if (m_gating) begin
                e_clear     = 1;
                m_gating    = 0;
                m_sleep_len = 0;
            end else if (m_draining) begin
                m_streak = bus_idle ? m_streak + 1 : 0;
                m_drain_age++;
                if (m_wake || m_drain_age == DRAIN_TIMEOUT) begin
                    e_abort    = 1;
                    m_draining = 0;
                end else if (m_streak >= DRAIN_STABLE) begin
                    m_draining = 0;
                    m_gating   = 1;
                end
            end else if (idle_req) begin
                m_draining  = 1;
                m_drain_age = 0;
                m_streak    = 0;
            end
        end
    end

    always @(negedge aclk) begin
        if (m_started) begin
            chk("model_clear", clear_clock_gate, e_clear);
            chk("model_set", set_clock_gate, e_set);
            chk("model_sleeping", core_sleeping, e_sleeping);
            chk("model_abort", idle_abort, e_abort);
            chk("model_done", wake_done, e_done);
            chk("model_sleep_cycles", sleep_cycles, m_total);
        end
    end

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; idle_req = 0; force_wake = 0; int_pending = '0; int_enable = '0; bus_idle = 1;
        step();
        step();
        reset = 1'b0;
    endtask

    // Leaves the bench in cycle T6 (first SLEEP cycle) after an idle request at T0 with bus_idle high.
    task automatic go_to_sleep();
        bus_idle = 1;
        step(); idle_req = 1;
        step(); idle_req = 0;
        repeat (5) step();
    endtask

    initial begin
        int seen;
        do_reset();
        chk("reset_clear", clear_clock_gate, 0);
        chk("reset_sleep_cycles", sleep_cycles, 0);

        // scenario 1: idle with bus idle, clear rises at T6
        bus_idle = 1;
        step(); idle_req = 1;
        step(); idle_req = 0;
        repeat (4) step();
        chk("t1_clear_T5", clear_clock_gate, 0);
        step();
        chk("t1_clear_T6", clear_clock_gate, 1);
        chk("t1_sleeping_T6", core_sleeping, 1);

        // scenario 2: enabled interrupt wakes, set pulses at T9
        int_pending[3] = 1; int_enable[3] = 1;
        step(); step();
        chk("t2_set_T8", set_clock_gate, 0);
        step();
        chk("t2_set_T9", set_clock_gate, 1);
        chk("t2_clear_T9", clear_clock_gate, 0);
        chk("t2_done_T9", wake_done, 1);
        chk("t2_cycles", sleep_cycles, 2);
        int_pending = '0; int_enable = '0;
        step();
        chk("t2_set_pulse_end", set_clock_gate, 0);

        // scenario 3: bus never idle, abort after 1024 drain cycles
        do_reset();
        bus_idle = 0;
        step(); idle_req = 1;
        step(); idle_req = 0;
        seen = 0;
        repeat (1023) begin
            step();
            if (clear_clock_gate || idle_abort) seen++;
        end
        chk("t3_no_early_abort", seen, 0);
        step();
        chk("t3_abort_T1025", idle_abort, 1);
        chk("t3_no_clear", clear_clock_gate, 0);
        step();
        chk("t3_abort_pulse_end", idle_abort, 0);

        // scenario 4: broken idle run delays gating until four consecutive highs
        do_reset();
        step(); idle_req = 1; bus_idle = 1;
        step(); idle_req = 0;
        for (int i = 0; i < 8; i++) begin
            bus_idle = (i == 3) ? 1'b0 : 1'b1;
            step();
        end
        bus_idle = 1;
        chk("t4_clear_T9", clear_clock_gate, 0);
        step();
        chk("t4_clear_T10", clear_clock_gate, 1);

        // scenario 5: force_wake at GATE, SLEEP lasts exactly two cycles
        do_reset();
        bus_idle = 1;
        step(); idle_req = 1;
        step(); idle_req = 0;
        repeat (4) step();
        force_wake = 1;
        repeat (4) step();
        chk("t5_set_T9", set_clock_gate, 1);
        chk("t5_cycles", sleep_cycles, 2);
        force_wake = 0;

        // scenario 6: reset mid-SLEEP, wake during DRAIN, masked interrupt
        do_reset();
        go_to_sleep();
        step();
        reset = 1;
        step();
        reset = 0;
        chk("t6_rst_clear", clear_clock_gate, 0);
        chk("t6_rst_sleeping", core_sleeping, 0);
        chk("t6_rst_cycles", sleep_cycles, 0);
        step(); idle_req = 1;
        step(); idle_req = 0;
        step(); force_wake = 1;
        step(); force_wake = 0;
        chk("t6_drain_abort", idle_abort, 1);
        chk("t6_drain_no_clear", clear_clock_gate, 0);
        step();
        go_to_sleep();
        int_pending = '1; int_enable = '0;
        seen = 0;
        repeat (20) begin
            step();
            if (set_clock_gate || !clear_clock_gate) seen++;
        end
        chk("t6_masked_stays_asleep", seen, 0);
        force_wake = 1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (set_clock_gate) seen++;
        end
        chk("t6_force_release", seen, 1);
        force_wake = 0; int_pending = '0;

        // randomized traffic, checked every cycle by the model
        do_reset();
        for (int i = 0; i < 15000; i++) begin
            idle_req   = ($urandom_range(0, 7) == 0);
            bus_idle   = ($urandom_range(0, 4) != 0);
            force_wake = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 29) == 0)
                int_pending = ($urandom_range(0, 1) == 0) ? '0 : NUM_INT'(1) << $urandom_range(0, NUM_INT - 1);
            if ($urandom_range(0, 199) == 0)
                int_enable = NUM_INT'($urandom);
            reset = ($urandom_range(0, 1999) == 0);
            step();
        end
        reset = 0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
